audio_sample_mixer: RTL and testbench
=====================================

# audio_sample_mixer

Parametrised audio mixing engine for the HDMI audio path, running in the pixel clock domain. It generates the audio-rate sample strobe and captures NUM_CH unsigned stereo sources, for example Mockingboard PSGs or future sound cards. It applies per-channel mute and attenuation, adds a pulse-limited Apple II speaker term, and accumulates sequentially, one channel per clock, so no DSP blocks are used. The saturated 16-bit stereo sample is presented to the HDMI encoder with a valid pulse.

## Interface
- CLOCK_SPEED_HZ, 27_000_000, frequency of clk_pixel_w.
- AUDIO_RATE, 44100, output sample rate.
- NUM_CH, 4, number of stereo input channels (1..8).
- CH_WIDTH, 10, unsigned bits per channel sample (≤ OUT_WIDTH).
- OUT_WIDTH, 16, output sample width.
- SPEAKER_HOLD, 255, maximum number of samples the speaker term stays asserted after a toggle.
- clk_pixel_w  in  1  clock.
- system_reset_n_w  in  1  asynchronous, active-low reset.
- ch_l_i  in  NUM_CH*CH_WIDTH  left samples; channel i occupies bits [i*CH_WIDTH +: CH_WIDTH].
- ch_r_i  in  NUM_CH*CH_WIDTH  right samples, same packing.
- ch_atten_i  in  NUM_CH*3  per-channel right-shift, 0..7.
- ch_mute_i  in  NUM_CH  1 = channel contributes 0.
- speaker_toggle_i  in  1  speaker level toggle from the logic clock domain (asynchronous).
- speaker_en_i  in  1  enables the speaker term.
- clip_clr_i  in  1  clears clip_o.
- sample_strobe_o  out  1  one-cycle pulse at AUDIO_RATE; replaces clk_audio.
- sample_l_o, sample_r_o  out  OUT_WIDTH  mixed samples, held between updates.
- sample_valid_o  out  1  one-cycle pulse when the sample outputs update.
- clip_o  out  1  sticky saturation flag.

## Operation
- Reset values: all outputs 0, state IDLE, divider 0, speaker counter 0, speaker level history 0.
- Divider: DIV = CLOCK_SPEED_HZ/AUDIO_RATE (integer, 612 at defaults). The counter runs 0..DIV-1, and sample_strobe_o=1 in the cycle the count equals DIV-1.
- An elaboration-time check requires DIV ≥ NUM_CH+4.
- Speaker synchroniser: speaker_toggle_i passes through a 2-flop synchroniser to give spk_s.
- Speaker update, on each strobe:
  - spk_active ← prev && cnt≠0 && speaker_en_i, using pre-update values.
  - If spk_s≠prev, cnt ← SPEAKER_HOLD; else if cnt≠0, cnt ← cnt-1.
  - prev ← spk_s.
- Scaling per channel: s = ({x, (OUT_WIDTH-CH_WIDTH) zeros}) >> atten. s = 0 if the channel is muted.
- The accumulator is OUT_WIDTH+clog2(NUM_CH+1) bits wide, one for left and one for right.
- FSM:
  - IDLE: on strobe, snapshot ch_l_i, ch_r_i, ch_atten_i and ch_mute_i, clear both accumulators, set idx=0, go to ACCUM.
  - ACCUM: add the scaled channel idx to both accumulators; idx++. After idx=NUM_CH-1, go to SPK.
  - SPK: if spk_active, add 2^(OUT_WIDTH-3) to both accumulators; go to OUT.
  - OUT: each side saturates to 2^OUT_WIDTH-1 and is registered to its output. Pulse sample_valid_o and go to IDLE.
- Clipping: clip_o is set if either side saturated in OUT. clip_clr_i clears it; if a set and a clear coincide, the set wins.
- Input changes after the snapshot do not affect the sample in progress.

## Timing
- Strobe at cycle T. ACCUM occupies T+1..T+NUM_CH, SPK is at T+NUM_CH+1, OUT at T+NUM_CH+2. sample_valid_o and the new data appear at T+NUM_CH+3.
- Toggle-to-speaker latency: 2 sync cycles, then the next strobe detects the change, then the strobe after that sets spk_active for the following sample.
- A speaker term started by a rising toggle lasts exactly SPEAKER_HOLD samples. A toggle back to 0 deactivates it from the next strobe.
- Reset mid-operation: the FSM aborts to IDLE, outputs go to 0 and no valid is emitted. The divider restarts from 0.

## Structure
- Package audio_sample_mixer_pkg contains:
  - state enum {IDLE, ACCUM, SPK, OUT};
  - function sat_u(acc, width);
  - localparam SPK_LEVEL_SHIFT = 3.
- Sub-module audio_strobe_gen holds the divider, parameterised by CLOCK_SPEED_HZ and AUDIO_RATE.

## Test plan
- Reset release, idle inputs -> first sample_strobe_o at cycle 611; sample_valid_o at cycle 618 with 0x0000 on both sides.
- ch0_l=10'h200, atten 0, others muted -> sample_l_o=0x8000, sample_r_o=0x0000, clip_o=0.
- ch0 and ch1 left=10'h3FF, atten 0 -> sample_l_o=0xFFFF, clip_o=1. clip_o stays 1 through later clean samples until clip_clr_i.
- ch2_r=10'h3FF, atten 3 -> sample_r_o=0x1FF8.
- speaker_toggle_i 0→1 with speaker_en_i=1 -> 0x2000 is added to exactly 255 consecutive samples, then 0. With speaker_en_i=0 the term never appears.
- Reset asserted during ACCUM, with ch_l_i changed mid-ACCUM in a separate run -> reset: outputs 0, no valid pulse. Changed input: the sample reflects the snapshotted values only.

Source files
------------

// File: rtl/audio_sample_mixer_pkg.sv
// Shared types and helpers for the audio sample mixer.
package audio_sample_mixer_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, SPK, OUT} state_t;

    localparam int SPK_LEVEL_SHIFT = 3;

    // Unsigned clamp of an accumulator value to 2^width-1.
    function automatic logic [31:0] sat_u(input logic [31:0] acc, input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (acc > max_v) ? max_v : acc;
    endfunction

endpackage

// File: rtl/audio_sample_mixer_if.sv
// Mixed-sample output bus towards the HDMI audio encoder.
interface audio_sample_mixer_if #(
    parameter int OUT_WIDTH = 16
);
    logic                 sample_strobe_o;
    logic [OUT_WIDTH-1:0] sample_l_o;
    logic [OUT_WIDTH-1:0] sample_r_o;
    logic                 sample_valid_o;
    logic                 clip_o;

    modport master (
        output sample_strobe_o, sample_l_o, sample_r_o, sample_valid_o, clip_o
    );

    modport slave (
        input sample_strobe_o, sample_l_o, sample_r_o, sample_valid_o, clip_o
    );
endinterface

// File: rtl/audio_sample_mixer_strobe_gen.sv
// Audio-rate strobe: free-running divider of the pixel clock.
module audio_strobe_gen #(
    parameter int CLOCK_SPEED_HZ = 27_000_000,
    parameter int AUDIO_RATE     = 44100
) (
    input  logic clk_pixel_w,
    input  logic system_reset_n_w,
    output logic o_strobe
);
    localparam int DIV   = CLOCK_SPEED_HZ / AUDIO_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_strobe = (r_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            r_cnt <= '0;
        end else if (o_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/audio_sample_mixer.sv
// Sequential stereo mixer: one channel per clock into wide accumulators,
// plus a pulse-limited speaker term, saturated to OUT_WIDTH on output.
//
//   state | meaning
//   IDLE  | wait for strobe, snapshot inputs, clear accumulators
//   ACCUM | add scaled channel idx to both sides
//   SPK   | add speaker term when active
//   OUT   | saturate, register outputs, pulse valid
module audio_sample_mixer
    import audio_sample_mixer_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 27_000_000,
    parameter int AUDIO_RATE     = 44100,
    parameter int NUM_CH         = 4,
    parameter int CH_WIDTH       = 10,
    parameter int OUT_WIDTH      = 16,
    parameter int SPEAKER_HOLD   = 255
) (
    input  logic                       clk_pixel_w,
    input  logic                       system_reset_n_w,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_l_i,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_r_i,
    input  logic [NUM_CH*3-1:0]        ch_atten_i,
    input  logic [NUM_CH-1:0]          ch_mute_i,
    input  logic                       speaker_toggle_i,
    input  logic                       speaker_en_i,
    input  logic                       clip_clr_i,
    audio_sample_mixer_if.master       out_if
);
    localparam int ACC_W  = OUT_WIDTH + $clog2(NUM_CH + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PAD    = OUT_WIDTH - CH_WIDTH;
    localparam int HOLD_W = $clog2(SPEAKER_HOLD + 1);
    localparam logic [ACC_W-1:0] SPK_TERM = ACC_W'(1) << (OUT_WIDTH - SPK_LEVEL_SHIFT);

    if (CLOCK_SPEED_HZ / AUDIO_RATE < NUM_CH + 4) begin : g_div_chk
        $error("audio_sample_mixer: divider too small for NUM_CH");
    end

    logic w_strobe;

    audio_strobe_gen #(
        .CLOCK_SPEED_HZ (CLOCK_SPEED_HZ),
        .AUDIO_RATE     (AUDIO_RATE)
    ) u_strobe (
        .clk_pixel_w      (clk_pixel_w),
        .system_reset_n_w (system_reset_n_w),
        .o_strobe         (w_strobe)
    );

    // Speaker toggle crosses from the logic clock domain.
    logic [1:0]        r_spk_sync;
    logic              w_spk_s;
    logic              r_spk_prev;
    logic              r_spk_active;
    logic [HOLD_W-1:0] r_spk_cnt;

    assign w_spk_s = r_spk_sync[1];

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            r_spk_sync   <= '0;
            r_spk_prev   <= 1'b0;
            r_spk_active <= 1'b0;
            r_spk_cnt    <= '0;
        end else begin
            r_spk_sync <= {r_spk_sync[0], speaker_toggle_i};
            if (w_strobe) begin
                r_spk_active <= r_spk_prev && (r_spk_cnt != '0) && speaker_en_i;
                if (w_spk_s != r_spk_prev) begin
                    r_spk_cnt <= HOLD_W'(SPEAKER_HOLD);
                end else if (r_spk_cnt != '0) begin
                    r_spk_cnt <= r_spk_cnt - 1'b1;
                end
                r_spk_prev <= w_spk_s;
            end
        end
    end

    state_t r_state, w_state_nxt;
    logic   w_snap, w_acc_en, w_spk_en, w_out_en;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_acc_en    = 1'b0;
        w_spk_en    = 1'b0;
        w_out_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_strobe) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_acc_en = 1'b1;
                if (r_idx == IDX_W'(NUM_CH - 1)) begin
                    w_state_nxt = SPK;
                end
            end
            SPK: begin
                w_spk_en    = 1'b1;
                w_state_nxt = OUT;
            end
            OUT: begin
                w_out_en    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic [NUM_CH*CH_WIDTH-1:0] r_snap_l, r_snap_r;
    logic [NUM_CH*3-1:0]        r_snap_atten;
    logic [NUM_CH-1:0]          r_snap_mute;
    logic [ACC_W-1:0]           r_acc_l, r_acc_r;

    logic [CH_WIDTH-1:0]  w_x_l, w_x_r;
    logic [2:0]           w_atten;
    logic [OUT_WIDTH-1:0] w_s_l, w_s_r;

    // Channel samples are MSB-aligned into OUT_WIDTH before attenuation.
    always_comb begin
        w_x_l   = r_snap_l[r_idx*CH_WIDTH +: CH_WIDTH];
        w_x_r   = r_snap_r[r_idx*CH_WIDTH +: CH_WIDTH];
        w_atten = r_snap_atten[r_idx*3 +: 3];
        w_s_l   = (OUT_WIDTH'(w_x_l) << PAD) >> w_atten;
        w_s_r   = (OUT_WIDTH'(w_x_r) << PAD) >> w_atten;
        if (r_snap_mute[r_idx]) begin
            w_s_l = '0;
            w_s_r = '0;
        end
    end

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            r_snap_l     <= '0;
            r_snap_r     <= '0;
            r_snap_atten <= '0;
            r_snap_mute  <= '0;
            r_acc_l      <= '0;
            r_acc_r      <= '0;
            r_idx        <= '0;
        end else if (w_snap) begin
            r_snap_l     <= ch_l_i;
            r_snap_r     <= ch_r_i;
            r_snap_atten <= ch_atten_i;
            r_snap_mute  <= ch_mute_i;
            r_acc_l      <= '0;
            r_acc_r      <= '0;
            r_idx        <= '0;
        end else if (w_acc_en) begin
            r_acc_l <= r_acc_l + ACC_W'(w_s_l);
            r_acc_r <= r_acc_r + ACC_W'(w_s_r);
            r_idx   <= r_idx + 1'b1;
        end else if (w_spk_en && r_spk_active) begin
            r_acc_l <= r_acc_l + SPK_TERM;
            r_acc_r <= r_acc_r + SPK_TERM;
        end
    end

    logic [31:0] w_acc_l32, w_acc_r32, w_sat_l32, w_sat_r32;
    logic        w_clip;

    assign w_acc_l32 = 32'(r_acc_l);
    assign w_acc_r32 = 32'(r_acc_r);
    assign w_sat_l32 = sat_u(w_acc_l32, OUT_WIDTH);
    assign w_sat_r32 = sat_u(w_acc_r32, OUT_WIDTH);
    assign w_clip    = (w_sat_l32 != w_acc_l32) || (w_sat_r32 != w_acc_r32);

    logic [OUT_WIDTH-1:0] r_sample_l, r_sample_r;
    logic                 r_valid, r_clip;

    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_valid    <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            r_valid <= w_out_en;
            if (w_out_en) begin
                r_sample_l <= w_sat_l32[OUT_WIDTH-1:0];
                r_sample_r <= w_sat_r32[OUT_WIDTH-1:0];
            end
            // A saturation in the same cycle as a clear keeps the flag set.
            if (w_out_en && w_clip) begin
                r_clip <= 1'b1;
            end else if (clip_clr_i) begin
                r_clip <= 1'b0;
            end
        end
    end

    assign out_if.sample_strobe_o = w_strobe;
    assign out_if.sample_l_o      = r_sample_l;
    assign out_if.sample_r_o      = r_sample_r;
    assign out_if.sample_valid_o  = r_valid;
    assign out_if.clip_o          = r_clip;
endmodule

// File: tb/tb_audio_sample_mixer.sv
// Self-checking bench for audio_sample_mixer: fixed vectors, random mixes
// against a reference model, and multi-cycle speaker/snapshot/reset sequences.
module tb_audio_sample_mixer;
    localparam int NCH = 4;
    localparam int CW  = 10;
    localparam int DIV = 16;
    localparam int LAT = DIV - 1 + NCH + 3;

    typedef struct {
        logic [NCH*CW-1:0] l;
        logic [NCH*CW-1:0] r;
        logic [NCH*3-1:0]  att;
        logic [NCH-1:0]    mute;
        logic              clr;
        logic [15:0]       exp_l;
        logic [15:0]       exp_r;
        logic              exp_clip;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*CW-1:0] ch_l, ch_r;
    logic [NCH*3-1:0]  att;
    logic [NCH-1:0]    mute;
    logic              spk_tgl, spk_en, clr;
    int                n_vec = 0;
    int                n_err = 0;
    bit                def_done = 1'b0;
    bit                clip_m = 1'b0;
    vec_t              tbl[8];

    always #5 clk = ~clk;

    audio_sample_mixer_if #(.OUT_WIDTH(16)) mix_if ();
    audio_sample_mixer_if #(.OUT_WIDTH(16)) def_if ();

    audio_sample_mixer #(
        .CLOCK_SPEED_HZ (DIV * 44100),
        .AUDIO_RATE     (44100),
        .NUM_CH         (NCH),
        .CH_WIDTH       (CW),
        .OUT_WIDTH      (16),
        .SPEAKER_HOLD   (255)
    ) dut (
        .clk_pixel_w      (clk),
        .system_reset_n_w (rst_n),
        .ch_l_i           (ch_l),
        .ch_r_i           (ch_r),
        .ch_atten_i       (att),
        .ch_mute_i        (mute),
        .speaker_toggle_i (spk_tgl),
        .speaker_en_i     (spk_en),
        .clip_clr_i       (clr),
        .out_if           (mix_if)
    );

    audio_sample_mixer dut_def (
        .clk_pixel_w      (clk),
        .system_reset_n_w (rst_n),
        .ch_l_i           ('0),
        .ch_r_i           ('0),
        .ch_atten_i       ('0),
        .ch_mute_i        ('0),
        .speaker_toggle_i (1'b0),
        .speaker_en_i     (1'b0),
        .clip_clr_i       (1'b0),
        .out_if           (def_if)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NCH*CW-1:0] l, input logic [NCH*CW-1:0] r,
                                input logic [NCH*3-1:0] a, input logic [NCH-1:0] m, input logic c,
                                input logic [15:0] el, input logic [15:0] er, input logic ec);
        vec_t v;
        v.l = l; v.r = r; v.att = a; v.mute = m; v.clr = c;
        v.exp_l = el; v.exp_r = er; v.exp_clip = ec;
        return v;
    endfunction

    // Reference mix: each channel value times 2^(16-10), divided by 2^atten.
    function automatic void ref_mix(input logic [NCH*CW-1:0] l, input logic [NCH*CW-1:0] r,
                                    input logic [NCH*3-1:0] a, input logic [NCH-1:0] m, input bit spk,
                                    output logic [15:0] ol, output logic [15:0] orr, output bit sat);
        int sl, sr;
        sl = spk ? 8192 : 0;
        sr = sl;
        for (int c = 0; c < NCH; c++) begin
            if (!m[c]) begin
                sl += (int'(l[c*CW +: CW]) * 64) / (1 << a[c*3 +: 3]);
                sr += (int'(r[c*CW +: CW]) * 64) / (1 << a[c*3 +: 3]);
            end
        end
        sat = (sl > 65535) || (sr > 65535);
        ol  = (sl > 65535) ? 16'hFFFF : 16'(sl);
        orr = (sr > 65535) ? 16'hFFFF : 16'(sr);
    endfunction

    task automatic apply(input vec_t v);
        ch_l = v.l; ch_r = v.r; att = v.att; mute = v.mute; clr = v.clr;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV && !ok; i++) begin
            @(negedge clk);
            ok = mix_if.sample_valid_o;
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV && !ok; i++) begin
            @(negedge clk);
            ok = mix_if.sample_strobe_o;
        end
    endtask

    task automatic cycles_to_valid(output int n);
        n = -1;
        for (int c = 1; c <= 4 * DIV && n < 0; c++) begin
            @(negedge clk);
            if (mix_if.sample_valid_o) n = c;
        end
    endtask

    task automatic sample_and_check(input string nm, input logic [15:0] el, input logic [15:0] er,
                                    input logic ec);
        bit ok;
        wait_valid(ok);
        check({nm, "_timeout"}, 32'(ok), 32'd1);
        check({nm, "_l"}, 32'(mix_if.sample_l_o), 32'(el));
        check({nm, "_r"}, 32'(mix_if.sample_r_o), 32'(er));
        check({nm, "_clip"}, 32'(mix_if.clip_o), 32'(ec));
    endtask

    // Speaker-only samples (all channels muted): term present for k in [on_lo, on_hi].
    task automatic spk_seq(input string nm, input int n, input int on_lo, input int on_hi);
        for (int k = 0; k < n; k++) begin
            bit ok;
            logic [15:0] e;
            e = (k >= on_lo && k <= on_hi) ? 16'h2000 : 16'h0000;
            wait_valid(ok);
            check({nm, "_timeout"}, 32'(ok), 32'd1);
            check({nm, "_l"}, 32'(mix_if.sample_l_o), 32'(e));
            check({nm, "_r"}, 32'(mix_if.sample_r_o), 32'(e));
        end
    endtask

    // Default-parameter instance: strobe and first valid timing after reset.
    initial begin
        int cyc_s, cyc_v;
        logic [15:0] vl, vr;
        cyc_s = -1; cyc_v = -1; vl = 16'hDEAD; vr = 16'hDEAD;
        @(posedge rst_n);
        for (int c = 1; c <= 700 && cyc_v < 0; c++) begin
            @(negedge clk);
            if (def_if.sample_strobe_o && cyc_s < 0) cyc_s = c;
            if (def_if.sample_valid_o) begin
                cyc_v = c; vl = def_if.sample_l_o; vr = def_if.sample_r_o;
            end
        end
        check("def_first_strobe", 32'(cyc_s), 32'd611);
        check("def_first_valid", 32'(cyc_v), 32'd618);
        check("def_first_l", 32'(vl), 32'h0);
        check("def_first_r", 32'(vr), 32'h0);
        def_done = 1'b1;
    end

    initial begin
        bit ok;
        int n;
        vec_t a, b;
        logic [15:0] el, er;
        bit sat;

        tbl[0] = mk(40'h200, '0, '0, 4'b1110, 1'b0, 16'h8000, 16'h0000, 1'b0);
        tbl[1] = mk(40'hFFFFF, '0, '0, 4'b1100, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        tbl[2] = mk('0, 40'h003FF00000, 12'h0C0, 4'b1011, 1'b0, 16'h0000, 16'h1FF8, 1'b1);
        tbl[3] = mk('0, 40'h003FF00000, 12'h0C0, 4'b1011, 1'b1, 16'h0000, 16'h1FF8, 1'b0);
        tbl[4] = mk({4{10'h100}}, 40'h1, {4{3'd1}}, 4'b0000, 1'b0, 16'h8000, 16'h0020, 1'b0);
        tbl[5] = mk({4{10'h3FF}}, {4{10'h3FF}}, '0, 4'b0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tbl[6] = mk({4{10'h3FF}}, {4{10'h3FF}}, '0, 4'b1111, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tbl[7] = mk({20'h0, 10'h3FF, 10'h0}, '0, {3'd0, 3'd0, 3'd7, 3'd0}, 4'b1101, 1'b1,
                    16'h01FF, 16'h0000, 1'b0);

        rst_n = 1'b0;
        ch_l = '0; ch_r = '0; att = '0; mute = '0;
        spk_tgl = 1'b0; spk_en = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(mix_if.sample_strobe_o), 32'd0);
        check("rst_valid", 32'(mix_if.sample_valid_o), 32'd0);
        check("rst_l", 32'(mix_if.sample_l_o), 32'd0);
        check("rst_r", 32'(mix_if.sample_r_o), 32'd0);
        check("rst_clip", 32'(mix_if.clip_o), 32'd0);
        rst_n = 1'b1;

        cycles_to_valid(n);
        check("first_valid_cycle", 32'(n), 32'(LAT));
        check("first_l", 32'(mix_if.sample_l_o), 32'd0);
        check("first_r", 32'(mix_if.sample_r_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            sample_and_check($sformatf("tbl%0d", i), tbl[i].exp_l, tbl[i].exp_r, tbl[i].exp_clip);
        end
        clip_m = 1'b0;

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            for (int c = 0; c < NCH; c++) begin
                v.l[c*CW +: CW] = CW'($urandom_range(0, 1023));
                v.r[c*CW +: CW] = CW'($urandom_range(0, 1023));
                v.att[c*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            end
            v.mute = 4'($urandom_range(0, 15));
            v.clr  = ($urandom_range(0, 5) == 0);
            ref_mix(v.l, v.r, v.att, v.mute, 1'b0, el, er, sat);
            clip_m = sat ? 1'b1 : (v.clr ? 1'b0 : clip_m);
            apply(v);
            sample_and_check("rnd", el, er, clip_m);
        end

        // Inputs changed mid-ACCUM must not disturb the sample in progress.
        a = mk(40'h155, 40'h0AA, '0, 4'b1110, 1'b0, '0, '0, 1'b0);
        b = mk({4{10'h3FF}}, '0, '0, 4'b0000, 1'b0, '0, '0, 1'b0);
        apply(a);
        wait_strobe(ok);
        check("snap_strobe_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        @(negedge clk);
        apply(b);
        ref_mix(a.l, a.r, a.att, a.mute, 1'b0, el, er, sat);
        clip_m = sat ? 1'b1 : clip_m;
        sample_and_check("snap_a", el, er, clip_m);
        ref_mix(b.l, b.r, b.att, b.mute, 1'b0, el, er, sat);
        clip_m = sat ? 1'b1 : clip_m;
        sample_and_check("snap_b", el, er, clip_m);

        for (int i = 0; i < 1000 && !def_done; i++) @(negedge clk);
        check("def_done", 32'(def_done), 32'd1);

        // Reset in the middle of ACCUM: outputs clear, the aborted sample never appears.
        apply(a);
        wait_strobe(ok);
        check("rst_strobe_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_l", 32'(mix_if.sample_l_o), 32'd0);
        check("mid_rst_r", 32'(mix_if.sample_r_o), 32'd0);
        check("mid_rst_valid", 32'(mix_if.sample_valid_o), 32'd0);
        check("mid_rst_clip", 32'(mix_if.clip_o), 32'd0);
        mute = '1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycles_to_valid(n);
        check("post_rst_valid_cycle", 32'(n), 32'(LAT));
        check("post_rst_l", 32'(mix_if.sample_l_o), 32'd0);

        spk_en  = 1'b1;
        spk_tgl = 1'b1;
        spk_seq("spk_hold", 260, 1, 255);
        spk_tgl = 1'b0;
        spk_seq("spk_fall", 2, 1, 0);
        spk_tgl = 1'b1;
        spk_seq("spk_short", 5, 1, 4);
        spk_tgl = 1'b0;
        spk_seq("spk_off", 3, 0, 0);
        spk_en  = 1'b0;
        spk_tgl = 1'b1;
        spk_seq("spk_dis", 10, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
